basic_control_unit: RTL and testbench
=====================================

Name: basic_control_unit

Overview:
Hardwired control unit that sequences the BC_I 16-bit datapath (AR, PC, DR, AC, IR, TR, memory, ALU, E and IEN flip-flops). It implements the Mano Basic Computer cycle: fetch, decode, optional indirect, then execute. It holds a 4-bit sequence counter (SC), decodes IR and the status flags, and drives every datapath control input each cycle. Execution stops on HLT.

Parameters:
WORD, 16, datapath word width; IR_IN width
ADDRESS, 12, address width; IR[ADDRESS-1:0] is the address field

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  async active-low reset
IR_IN  in  WORD  datapath IR_OUT
STATUS_AC_N, STATUS_AC_Z, STATUS_DR_Z, STATUS_IEN, E_IN  in  1 each  datapath status flags; E_IN = OUT_CO
irq  in  1  interrupt request; ignored unless INTERRUPT_EN
select_BUS  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 M
select_ALU  out  3  ALU op code (package)
write_enable_X, reset_X, incr_X  out  1 each  for X in AR, PC, DR, AC, IR, TR
write_enable_M  out  1  memory write
write_enable_CO, reset_CO, cmp_CO  out  1  E control
SET_IEN, RESET_IEN  out  1  IEN control
sc  out  4  current sequence count (debug)
halted  out  1  HLT executed

Behaviour:
- Reset (async): SC=0, I=0, halted=0, R=0. All control outputs are combinational from SC/IR/I/R/flags and are 0 while reset_n=0 or halted=1.
- Unlisted controls are 0 in every state. SC increments each cycle; "clr" means SC<-0 at the next edge.
- T0: bus=2, we_AR.
- T1: bus=7, we_IR, incr_PC.
- T2: bus=5, we_AR (AR<-IR[11:0]); register I<-IR[15]. Opcode D=IR[14:12].
- T3, D!=7: if I, then bus=7, we_AR; otherwise idle.
- T3, D=7, I=0 (register reference, one-hot IR[11:0], clr at end):
  - CLA b11: reset_AC. CLE b10: reset_CO. CMA b9: ALU_CMA, we_AC. CME b8: cmp_CO.
  - CIR b7: ALU_CIR, we_AC, we_CO. CIL b6: ALU_CIL, we_AC, we_CO. INC b5: incr_AC.
  - SPA b4: incr_PC if !AC_N. SNA b3: incr_PC if AC_N. SZA b2: incr_PC if AC_Z. SZE b1: incr_PC if !E_IN.
  - HLT b0: halted<-1.
  - Multiple set bits: AC ops take priority CLA>CMA>CIR>CIL>INC (one only); E ops take priority CLE>CME>(CIR/CIL carry). Skips are OR-ed into a single incr_PC. HLT combines with all of them.
- T3, D=7, I=1 (I/O): no-op, clr (except as given under Optional Feature).
- Memory reference execute, from T4:
  - AND: T4 bus=7, we_DR; T5 ALU_AND, we_AC, clr.
  - ADD: T4 as AND; T5 ALU_ADD, we_AC, we_CO, clr.
  - LDA: T4 as AND; T5 ALU_DR, we_AC, clr.
  - STA: T4 bus=4, we_M, clr.
  - BUN: T4 bus=1, we_PC, clr.
  - BSA: T4 bus=2, we_M, incr_AR; T5 bus=1, we_PC, clr.
  - ISZ: T4 bus=7, we_DR; T5 incr_DR; T6 bus=3, we_M, incr_PC if DR_Z (DR_Z already reflects the incremented DR), clr.
- Cycle counts: register-reference and I/O 4; STA/BUN 5 (+1 if indirect); AND/ADD/LDA/BSA 6 (+1); ISZ 7 (+1).
- SC reaching 15 is illegal; force clr.
- halted is sticky; only reset clears it.

Optional Feature:
INTERRUPT_EN.
- Defined:
  - R<-1 at any edge where SC is not 0, 1 or 2 and STATUS_IEN & irq.
  - When SC=0 and R=1, the interrupt cycle replaces fetch:
    - RT0: reset_AR, bus=2, we_TR.
    - RT1: bus=6, we_M, reset_PC.
    - RT2: incr_PC, RESET_IEN, R<-0, clr.
  - I/O instruction IR=F080 (ION) drives SET_IEN; IR=F040 (IOF) drives RESET_IEN.
- Undefined: irq is ignored, R is held at 0, and ION/IOF are no-ops.

Decomposition:
- Package bc_ctrl_pkg holds:
  - BUS_* select constants.
  - ALU_* codes: AND=0, ADD=1, DR=2, CMA=3, CIR=4, CIL=5, AC=6.
  - Opcode constants OP_AND..OP_IO.
  - Register-reference bit indices.
- One sub-module, bc_seq_counter: 4-bit SC with async reset, clr and increment.
- Decode and control-word generation stay in basic_control_unit.

Test Plan:
- Assert reset_n=0 mid-T1 -> sc=0 and all controls 0 immediately; after release, fetch restarts at PC's current value.
- M[0]=2010, M[010]=1234 -> after 6 cycles AC=1234, PC=001, sc=0.
- M[0]=9011, M[011]=0020, M[020]=0005, AC=0003 -> after 7 cycles AC=0008, E=0.
- M[0]=6012, M[012]=FFFF -> after 7 cycles M[012]=0000, PC=002 (skip taken); repeat with 0005 -> M[012]=0006, PC=001.
- M[0]=5030 -> M[030]=0001, PC=031 after 6 cycles. Then M[031]=7820 (CLA|INC) -> AC=0000 (CLA wins).
- HLT (7001) -> halted=1 after 4 cycles, and no control asserted for 20 further clocks. With INTERRUPT_EN: IEN=1, irq during T4 of an STA -> M[000]=return PC, PC=001, IEN=0.

Source files
------------

// File: rtl/bc_ctrl_pkg.sv
// Shared constants and the control-word type for the Basic Computer control unit.
// Bus selects, ALU codes, opcodes and register-reference bit positions live here.
package bc_ctrl_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_M    = 3'd7;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_DR  = 3'd2;
  localparam logic [2:0] ALU_CMA = 3'd3;
  localparam logic [2:0] ALU_CIR = 3'd4;
  localparam logic [2:0] ALU_CIL = 3'd5;
  localparam logic [2:0] ALU_AC  = 3'd6;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  localparam logic [3:0] SC_ILLEGAL = 4'hF;

  // One cycle's worth of datapath controls plus the unit's own housekeeping strobes.
  typedef struct packed {
    logic [2:0] bus;
    logic [2:0] alu;
    logic       we_ar, rst_ar, inc_ar;
    logic       we_pc, rst_pc, inc_pc;
    logic       we_dr, rst_dr, inc_dr;
    logic       we_ac, rst_ac, inc_ac;
    logic       we_ir, rst_ir, inc_ir;
    logic       we_tr, rst_tr, inc_tr;
    logic       we_m;
    logic       we_co, rst_co, cmp_co;
    logic       set_ien, rst_ien;
    logic       clr;
    logic       hlt;
    logic       clr_r;
  } ctrl_t;

endpackage

// File: rtl/basic_control_unit_seq_counter.sv
// bc_seq_counter: 4-bit timing sequence counter with async active-low reset,
// synchronous clear (priority) and count enable.
module bc_seq_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_sc
);

  logic [3:0] r_sc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_sc <= 4'd0;
    else if (i_clr) r_sc <= 4'd0;
    else if (i_en)  r_sc <= r_sc + 4'd1;
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/basic_control_unit.sv
// Hardwired control unit for the Mano Basic Computer: fetch, decode, indirect, execute.
// Define INTERRUPT_EN to enable the interrupt cycle and the ION/IOF instructions.
module basic_control_unit
  import bc_ctrl_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int ADDRESS = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [WORD-1:0] IR_IN,
  input  logic            STATUS_AC_N,
  input  logic            STATUS_AC_Z,
  input  logic            STATUS_DR_Z,
  input  logic            STATUS_IEN,
  input  logic            E_IN,
  input  logic            irq,
  output logic [2:0]      select_BUS,
  output logic [2:0]      select_ALU,
  output logic            write_enable_AR, reset_AR, incr_AR,
  output logic            write_enable_PC, reset_PC, incr_PC,
  output logic            write_enable_DR, reset_DR, incr_DR,
  output logic            write_enable_AC, reset_AC, incr_AC,
  output logic            write_enable_IR, reset_IR, incr_IR,
  output logic            write_enable_TR, reset_TR, incr_TR,
  output logic            write_enable_M,
  output logic            write_enable_CO, reset_CO, cmp_CO,
  output logic            SET_IEN, RESET_IEN,
  output logic [3:0]      sc,
  output logic            halted
);

  logic [3:0]         w_sc;
  logic [3:0]         w_step;
  logic [2:0]         w_opcode;
  logic [ADDRESS-1:0] w_rr;
  logic               w_active;
  logic               w_rotate;
  logic               r_i;
  logic               r_halted;
  logic               r_r;
  ctrl_t              w_ctrl;
  ctrl_t              w_out;

  assign w_opcode = IR_IN[WORD-2 -: 3];
  assign w_rr     = IR_IN[ADDRESS-1:0];
  assign w_active = reset_n & ~r_halted;
  // An indirect fetch costs one extra settle cycle, so execute steps start one later.
  assign w_step   = w_sc - {3'b000, r_i} - 4'd4;

  bc_seq_counter u_sc (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_clr   (w_out.clr),
    .i_en    (w_active),
    .o_sc    (w_sc)
  );

  always_comb begin
    w_ctrl   = '0;
    w_rotate = 1'b0;
    if (w_sc == SC_ILLEGAL) begin
      w_ctrl.clr = 1'b1;
    end else if (r_r && w_sc <= 4'd2) begin
      case (w_sc)
        4'd0: begin w_ctrl.rst_ar = 1'b1; w_ctrl.bus = BUS_PC; w_ctrl.we_tr = 1'b1; end
        4'd1: begin w_ctrl.bus = BUS_TR; w_ctrl.we_m = 1'b1; w_ctrl.rst_pc = 1'b1; end
        default: begin
          w_ctrl.inc_pc  = 1'b1;
          w_ctrl.rst_ien = 1'b1;
          w_ctrl.clr_r   = 1'b1;
          w_ctrl.clr     = 1'b1;
        end
      endcase
    end else begin
      case (w_sc)
        4'd0: begin w_ctrl.bus = BUS_PC; w_ctrl.we_ar = 1'b1; end
        4'd1: begin w_ctrl.bus = BUS_M; w_ctrl.we_ir = 1'b1; w_ctrl.inc_pc = 1'b1; end
        4'd2: begin w_ctrl.bus = BUS_IR; w_ctrl.we_ar = 1'b1; end
        4'd3: begin
          if (w_opcode != OP_IO) begin
            if (r_i) begin w_ctrl.bus = BUS_M; w_ctrl.we_ar = 1'b1; end
          end else if (!r_i) begin
            if (w_rr[RR_CLA])      w_ctrl.rst_ac = 1'b1;
            else if (w_rr[RR_CMA]) begin w_ctrl.alu = ALU_CMA; w_ctrl.we_ac = 1'b1; end
            else if (w_rr[RR_CIR]) begin w_ctrl.alu = ALU_CIR; w_ctrl.we_ac = 1'b1; w_rotate = 1'b1; end
            else if (w_rr[RR_CIL]) begin w_ctrl.alu = ALU_CIL; w_ctrl.we_ac = 1'b1; w_rotate = 1'b1; end
            else if (w_rr[RR_INC]) w_ctrl.inc_ac = 1'b1;
            if (w_rr[RR_CLE])      w_ctrl.rst_co = 1'b1;
            else if (w_rr[RR_CME]) w_ctrl.cmp_co = 1'b1;
            else if (w_rotate)     w_ctrl.we_co  = 1'b1;
            w_ctrl.inc_pc = (w_rr[RR_SPA] & ~STATUS_AC_N) | (w_rr[RR_SNA] & STATUS_AC_N) |
                            (w_rr[RR_SZA] & STATUS_AC_Z)  | (w_rr[RR_SZE] & ~E_IN);
            w_ctrl.hlt = w_rr[RR_HLT];
            w_ctrl.clr = 1'b1;
          end else begin
`ifdef INTERRUPT_EN
            w_ctrl.set_ien = (IR_IN == 16'hF080);
            w_ctrl.rst_ien = (IR_IN == 16'hF040);
`endif
            w_ctrl.clr = 1'b1;
          end
        end
        default: begin
          if (w_opcode == OP_IO) begin
            w_ctrl.clr = 1'b1;
          end else if (!(r_i && w_sc == 4'd4)) begin
            case (w_opcode)
              OP_AND, OP_ADD, OP_LDA: begin
                if (w_step == 4'd0) begin
                  w_ctrl.bus = BUS_M; w_ctrl.we_dr = 1'b1;
                end else begin
                  w_ctrl.alu   = (w_opcode == OP_AND) ? ALU_AND :
                                 (w_opcode == OP_ADD) ? ALU_ADD : ALU_DR;
                  w_ctrl.we_ac = (w_step == 4'd1);
                  w_ctrl.we_co = (w_step == 4'd1) && (w_opcode == OP_ADD);
                  w_ctrl.clr   = 1'b1;
                end
              end
              OP_STA: begin w_ctrl.bus = BUS_AC; w_ctrl.we_m = 1'b1; w_ctrl.clr = 1'b1; end
              OP_BUN: begin w_ctrl.bus = BUS_AR; w_ctrl.we_pc = 1'b1; w_ctrl.clr = 1'b1; end
              OP_BSA: begin
                if (w_step == 4'd0) begin
                  w_ctrl.bus = BUS_PC; w_ctrl.we_m = 1'b1; w_ctrl.inc_ar = 1'b1;
                end else begin
                  w_ctrl.bus = BUS_AR; w_ctrl.we_pc = 1'b1; w_ctrl.clr = 1'b1;
                end
              end
              default: begin
                case (w_step)
                  4'd0: begin w_ctrl.bus = BUS_M; w_ctrl.we_dr = 1'b1; end
                  4'd1: w_ctrl.inc_dr = 1'b1;
                  4'd2: begin
                    w_ctrl.bus    = BUS_DR;
                    w_ctrl.we_m   = 1'b1;
                    w_ctrl.inc_pc = STATUS_DR_Z;
                    w_ctrl.clr    = 1'b1;
                  end
                  default: w_ctrl.clr = 1'b1;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

  assign w_out = w_active ? w_ctrl : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_active && !r_r && w_sc == 4'd2) r_i <= IR_IN[WORD-1];
      if (w_out.hlt) r_halted <= 1'b1;
    end
  end

`ifdef INTERRUPT_EN
  // Requests are only sampled outside T0-T2 so an in-flight fetch is never split.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_r <= 1'b0;
    else if (w_out.clr_r) r_r <= 1'b0;
    else if (w_active && w_sc > 4'd2 && STATUS_IEN && irq) r_r <= 1'b1;
  end
`else
  logic w_unused_irq;
  assign w_unused_irq = irq ^ STATUS_IEN ^ w_out.clr_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_r <= 1'b0;
    else          r_r <= 1'b0;
  end
`endif

  assign select_BUS      = w_out.bus;
  assign select_ALU      = w_out.alu;
  assign write_enable_AR = w_out.we_ar;
  assign reset_AR        = w_out.rst_ar;
  assign incr_AR         = w_out.inc_ar;
  assign write_enable_PC = w_out.we_pc;
  assign reset_PC        = w_out.rst_pc;
  assign incr_PC         = w_out.inc_pc;
  assign write_enable_DR = w_out.we_dr;
  assign reset_DR        = w_out.rst_dr;
  assign incr_DR         = w_out.inc_dr;
  assign write_enable_AC = w_out.we_ac;
  assign reset_AC        = w_out.rst_ac;
  assign incr_AC         = w_out.inc_ac;
  assign write_enable_IR = w_out.we_ir;
  assign reset_IR        = w_out.rst_ir;
  assign incr_IR         = w_out.inc_ir;
  assign write_enable_TR = w_out.we_tr;
  assign reset_TR        = w_out.rst_tr;
  assign incr_TR         = w_out.inc_tr;
  assign write_enable_M  = w_out.we_m;
  assign write_enable_CO = w_out.we_co;
  assign reset_CO        = w_out.rst_co;
  assign cmp_CO          = w_out.cmp_co;
  assign SET_IEN         = w_out.set_ien;
  assign RESET_IEN       = w_out.rst_ien;
  assign sc              = w_sc;
  assign halted          = r_halted;

endmodule

// File: tb/tb_basic_control_unit.sv
// Directed bench for basic_control_unit: drives IR and flags per timing step and
// compares the full control word, sc and halted against hand-written expectations.
module tb_basic_control_unit;

  localparam logic [23:0] WE_AR  = 24'h000001;
  localparam logic [23:0] RST_AR = 24'h000002;
  localparam logic [23:0] INC_AR = 24'h000004;
  localparam logic [23:0] WE_PC  = 24'h000008;
  localparam logic [23:0] RST_PC = 24'h000010;
  localparam logic [23:0] INC_PC = 24'h000020;
  localparam logic [23:0] WE_DR  = 24'h000040;
  localparam logic [23:0] INC_DR = 24'h000100;
  localparam logic [23:0] WE_AC  = 24'h000200;
  localparam logic [23:0] RST_AC = 24'h000400;
  localparam logic [23:0] INC_AC = 24'h000800;
  localparam logic [23:0] WE_IR  = 24'h001000;
  localparam logic [23:0] WE_TR  = 24'h008000;
  localparam logic [23:0] WE_M   = 24'h040000;
  localparam logic [23:0] WE_CO  = 24'h080000;
  localparam logic [23:0] RST_CO = 24'h100000;
  localparam logic [23:0] CMP_CO = 24'h200000;
  localparam logic [23:0] S_IEN  = 24'h400000;
  localparam logic [23:0] R_IEN  = 24'h800000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] IR_IN;
  logic        STATUS_AC_N, STATUS_AC_Z, STATUS_DR_Z, STATUS_IEN, E_IN, irq;
  logic [2:0]  select_BUS, select_ALU;
  logic        write_enable_AR, reset_AR, incr_AR;
  logic        write_enable_PC, reset_PC, incr_PC;
  logic        write_enable_DR, reset_DR, incr_DR;
  logic        write_enable_AC, reset_AC, incr_AC;
  logic        write_enable_IR, reset_IR, incr_IR;
  logic        write_enable_TR, reset_TR, incr_TR;
  logic        write_enable_M, write_enable_CO, reset_CO, cmp_CO;
  logic        SET_IEN, RESET_IEN;
  logic [3:0]  sc;
  logic        halted;
  logic [23:0] obsMask;
  logic [34:0] observed;
  int          checks = 0;
  int          errors = 0;

  basic_control_unit dut (
    .clk(clk), .reset_n(reset_n), .IR_IN(IR_IN),
    .STATUS_AC_N(STATUS_AC_N), .STATUS_AC_Z(STATUS_AC_Z), .STATUS_DR_Z(STATUS_DR_Z),
    .STATUS_IEN(STATUS_IEN), .E_IN(E_IN), .irq(irq),
    .select_BUS(select_BUS), .select_ALU(select_ALU),
    .write_enable_AR(write_enable_AR), .reset_AR(reset_AR), .incr_AR(incr_AR),
    .write_enable_PC(write_enable_PC), .reset_PC(reset_PC), .incr_PC(incr_PC),
    .write_enable_DR(write_enable_DR), .reset_DR(reset_DR), .incr_DR(incr_DR),
    .write_enable_AC(write_enable_AC), .reset_AC(reset_AC), .incr_AC(incr_AC),
    .write_enable_IR(write_enable_IR), .reset_IR(reset_IR), .incr_IR(incr_IR),
    .write_enable_TR(write_enable_TR), .reset_TR(reset_TR), .incr_TR(incr_TR),
    .write_enable_M(write_enable_M), .write_enable_CO(write_enable_CO),
    .reset_CO(reset_CO), .cmp_CO(cmp_CO), .SET_IEN(SET_IEN), .RESET_IEN(RESET_IEN),
    .sc(sc), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obsMask = {RESET_IEN, SET_IEN, cmp_CO, reset_CO, write_enable_CO, write_enable_M,
                    incr_TR, reset_TR, write_enable_TR, incr_IR, reset_IR, write_enable_IR,
                    incr_AC, reset_AC, write_enable_AC, incr_DR, reset_DR, write_enable_DR,
                    incr_PC, reset_PC, write_enable_PC, incr_AR, reset_AR, write_enable_AR};
  assign observed = {sc, halted, select_BUS, select_ALU, obsMask};

  // Called just after a falling edge: sample 1 ns later, then move to the next falling edge.
  task automatic checkOutput(input string tag, input logic [3:0] eSc, input logic eHalt,
                             input logic [2:0] eBus, input logic [2:0] eAlu,
                             input logic [23:0] eMask);
    logic [34:0] expected;
    expected = {eSc, eHalt, eBus, eAlu, eMask};
    #1;
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed sc/h/bus/alu/mask=%h required=%h", tag, observed, expected);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] ir, input logic acn, input logic acz,
                               input logic drz, input logic e);
    IR_IN       = ir;
    STATUS_AC_N = acn;
    STATUS_AC_Z = acz;
    STATUS_DR_Z = drz;
    E_IN        = e;
  endtask

  task automatic fetch(input string tag);
    checkOutput({tag, "_T0"}, 4'd0, 1'b0, 3'd2, 3'd0, WE_AR);
    checkOutput({tag, "_T1"}, 4'd1, 1'b0, 3'd7, 3'd0, WE_IR | INC_PC);
    checkOutput({tag, "_T2"}, 4'd2, 1'b0, 3'd5, 3'd0, WE_AR);
  endtask

  task automatic regRef(input string tag, input logic [15:0] ir, input logic acn,
                        input logic acz, input logic e, input logic [2:0] eAlu,
                        input logic [23:0] eMask);
    applyStimulus(ir, acn, acz, 1'b0, e);
    fetch(tag);
    checkOutput({tag, "_T3"}, 4'd3, 1'b0, 3'd0, eAlu, eMask);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n    = 1'b0;
    STATUS_IEN = 1'b0;
    irq        = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("in_reset", 4'd0, 1'b0, 3'd0, 3'd0, 24'h0);
    reset_n = 1'b1;
    checkOutput("post_reset_T0", 4'd0, 1'b0, 3'd2, 3'd0, WE_AR);
    reset_n = 1'b0;
    checkOutput("reset_mid_T1", 4'd0, 1'b0, 3'd0, 3'd0, 24'h0);
    reset_n = 1'b1;

    applyStimulus(16'h2010, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("lda");
    checkOutput("lda_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("lda_T4", 4'd4, 1'b0, 3'd7, 3'd0, WE_DR);
    checkOutput("lda_T5", 4'd5, 1'b0, 3'd0, 3'd2, WE_AC);

    applyStimulus(16'h9011, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("addi");
    checkOutput("addi_T3", 4'd3, 1'b0, 3'd7, 3'd0, WE_AR);
    checkOutput("addi_T4", 4'd4, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("addi_T5", 4'd5, 1'b0, 3'd7, 3'd0, WE_DR);
    checkOutput("addi_T6", 4'd6, 1'b0, 3'd0, 3'd1, WE_AC | WE_CO);

    applyStimulus(16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("and");
    checkOutput("and_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("and_T4", 4'd4, 1'b0, 3'd7, 3'd0, WE_DR);
    checkOutput("and_T5", 4'd5, 1'b0, 3'd0, 3'd0, WE_AC);

    for (int k = 0; k < 2; k++) begin
      applyStimulus(16'h6012, 1'b0, 1'b0, 1'b0, 1'b0);
      fetch("isz");
      checkOutput("isz_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
      checkOutput("isz_T4", 4'd4, 1'b0, 3'd7, 3'd0, WE_DR);
      checkOutput("isz_T5", 4'd5, 1'b0, 3'd0, 3'd0, INC_DR);
      STATUS_DR_Z = (k == 0);
      checkOutput("isz_T6", 4'd6, 1'b0, 3'd3, 3'd0, (k == 0) ? (WE_M | INC_PC) : WE_M);
    end

    applyStimulus(16'h5030, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("bsa");
    checkOutput("bsa_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("bsa_T4", 4'd4, 1'b0, 3'd2, 3'd0, WE_M | INC_AR);
    checkOutput("bsa_T5", 4'd5, 1'b0, 3'd1, 3'd0, WE_PC);

    applyStimulus(16'h3040, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("sta");
    checkOutput("sta_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("sta_T4", 4'd4, 1'b0, 3'd4, 3'd0, WE_M);

    applyStimulus(16'hC050, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("buni");
    checkOutput("buni_T3", 4'd3, 1'b0, 3'd7, 3'd0, WE_AR);
    checkOutput("buni_T4", 4'd4, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("buni_T5", 4'd5, 1'b0, 3'd1, 3'd0, WE_PC);

    regRef("cla_inc", 16'h7820, 1'b0, 1'b0, 1'b0, 3'd0, RST_AC);
    regRef("cla_cle", 16'h7C00, 1'b0, 1'b0, 1'b0, 3'd0, RST_AC | RST_CO);
    regRef("cir",     16'h7080, 1'b0, 1'b0, 1'b0, 3'd4, WE_AC | WE_CO);
    regRef("cle_cir", 16'h7480, 1'b0, 1'b0, 1'b0, 3'd4, WE_AC | RST_CO);
    regRef("cil",     16'h7040, 1'b0, 1'b0, 1'b0, 3'd5, WE_AC | WE_CO);
    regRef("cma_inc", 16'h7220, 1'b0, 1'b0, 1'b0, 3'd3, WE_AC);
    regRef("cme",     16'h7100, 1'b0, 1'b0, 1'b0, 3'd0, CMP_CO);
    regRef("inc",     16'h7020, 1'b0, 1'b0, 1'b0, 3'd0, INC_AC);
    regRef("spa_sna", 16'h7018, 1'b1, 1'b0, 1'b0, 3'd0, INC_PC);
    regRef("spa_neg", 16'h7010, 1'b1, 1'b0, 1'b0, 3'd0, 24'h0);
    regRef("sze_e1",  16'h7002, 1'b0, 1'b0, 1'b1, 3'd0, 24'h0);
    regRef("sze_e0",  16'h7002, 1'b0, 1'b0, 1'b0, 3'd0, INC_PC);
    regRef("sza",     16'h7004, 1'b0, 1'b1, 1'b1, 3'd0, INC_PC);
`ifdef INTERRUPT_EN
    regRef("ion",     16'hF080, 1'b0, 1'b0, 1'b0, 3'd0, S_IEN);
    regRef("iof",     16'hF040, 1'b0, 1'b0, 1'b0, 3'd0, R_IEN);
`else
    regRef("ion",     16'hF080, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
    regRef("iof",     16'hF040, 1'b0, 1'b0, 1'b0, 3'd0, 24'h0);
`endif
    checkOutput("io_next_T0", 4'd0, 1'b0, 3'd2, 3'd0, WE_AR);
    checkOutput("io_next_T1", 4'd1, 1'b0, 3'd7, 3'd0, WE_IR | INC_PC);
    checkOutput("io_next_T2", 4'd2, 1'b0, 3'd5, 3'd0, WE_AR);
    checkOutput("io_next_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);

`ifdef INTERRUPT_EN
    STATUS_IEN = 1'b1;
    applyStimulus(16'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("irq_sta");
    checkOutput("irq_sta_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    irq = 1'b1;
    checkOutput("irq_sta_T4", 4'd4, 1'b0, 3'd4, 3'd0, WE_M);
    irq = 1'b0;
    checkOutput("irq_RT0", 4'd0, 1'b0, 3'd2, 3'd0, RST_AR | WE_TR);
    checkOutput("irq_RT1", 4'd1, 1'b0, 3'd6, 3'd0, WE_M | RST_PC);
    checkOutput("irq_RT2", 4'd2, 1'b0, 3'd0, 3'd0, INC_PC | R_IEN);
    STATUS_IEN = 1'b0;
    fetch("after_irq");
    checkOutput("after_irq_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("after_irq_T4", 4'd4, 1'b0, 3'd4, 3'd0, WE_M);
`else
    irq        = 1'b1;
    STATUS_IEN = 1'b1;
    applyStimulus(16'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("noirq_sta");
    checkOutput("noirq_sta_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("noirq_sta_T4", 4'd4, 1'b0, 3'd4, 3'd0, WE_M);
    checkOutput("noirq_next_T0", 4'd0, 1'b0, 3'd2, 3'd0, WE_AR);
    irq        = 1'b0;
    STATUS_IEN = 1'b0;
    checkOutput("noirq_next_T1", 4'd1, 1'b0, 3'd7, 3'd0, WE_IR | INC_PC);
    checkOutput("noirq_next_T2", 4'd2, 1'b0, 3'd5, 3'd0, WE_AR);
    checkOutput("noirq_next_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    checkOutput("noirq_next_T4", 4'd4, 1'b0, 3'd4, 3'd0, WE_M);
`endif

    applyStimulus(16'h7001, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch("hlt");
    checkOutput("hlt_T3", 4'd3, 1'b0, 3'd0, 3'd0, 24'h0);
    for (int n = 0; n < 20; n++) begin
      checkOutput("halted_idle", 4'd0, 1'b1, 3'd0, 3'd0, 24'h0);
    end
    reset_n = 1'b0;
    checkOutput("halt_reset", 4'd0, 1'b0, 3'd0, 3'd0, 24'h0);
    reset_n = 1'b1;
    fetch("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
